// File: rtl/dual_nibble_loader.sv
// dual_nibble_loader
//
// Collects two operand nibbles from a valid/ready stream. The first accepted
// nibble is A and the second is B. Once both are held, enab is driven high for
// HOLD_CYCLES consecutive cycles. The cycle after that window, done pulses
// for one cycle.
//
// Parameters
//   WIDTH        width of in_data, A and B
//   HOLD_CYCLES  length of the enab window in cycles (1..255)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   clear     synchronous abort: back to IDLE, A/B zeroed, no done
//   in_valid  upstream nibble valid
//   in_data   upstream nibble
//   in_ready  nibble can be accepted this cycle (IDLE or WAIT_B)
//   A, B      registered operands
//   enab      registered enable, high only while in DRIVE
//   busy      high whenever the FSM is not in IDLE
//   done      one-cycle pulse in the first IDLE cycle after a full window
module dual_nibble_loader #(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             enab,
    output logic             busy,
    output logic             done
);

    // The counter only needs to hold HOLD_CYCLES-1. Keep it at least 1 bit wide
    // so that HOLD_CYCLES=1 still produces a legal vector.
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        DRIVE  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [WIDTH-1:0]  a_n, b_n;
    logic              enab_n, done_n;
    logic              xfer;

    // in_ready and busy come from the state register alone, so an asynchronous
    // reset moves them to their idle values at once.
    assign in_ready = (state != DRIVE);
    assign busy     = (state != IDLE);
    assign xfer     = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            A     <= '0;
            B     <= '0;
            enab  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            A     <= a_n;
            B     <= b_n;
            enab  <= enab_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_n     = A;
        b_n     = B;
        enab_n  = 1'b0;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (xfer) begin
                    a_n     = in_data;
                    state_n = WAIT_B;
                end
            end
            WAIT_B: begin
                if (xfer) begin
                    b_n     = in_data;
                    cnt_n   = CNT_LOAD;
                    enab_n  = 1'b1;
                    state_n = DRIVE;
                end
            end
            DRIVE: begin
                // The counter runs from HOLD_CYCLES-1 down to 0, which gives
                // exactly HOLD_CYCLES cycles in DRIVE. The edge where it is 0
                // closes the window.
                if (cnt == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n   = cnt - 1'b1;
                    enab_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // clear has priority over everything, including a transfer on the same edge.
        if (clear) begin
            state_n = IDLE;
            cnt_n   = '0;
            a_n     = '0;
            b_n     = '0;
            enab_n  = 1'b0;
            done_n  = 1'b0;
        end
    end

endmodule

// File: tb/tb_dual_nibble_loader.sv
// Randomized and directed bench for dual_nibble_loader. Two instances run side
// by side (HOLD_CYCLES=4 and HOLD_CYCLES=1) and share all inputs. Each
// instance is checked every cycle against a transaction-level model.
module tb_dual_nibble_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;

    logic       d_ready [2];
    logic [3:0] d_a     [2];
    logic [3:0] d_b     [2];
    logic       d_enab  [2];
    logic       d_busy  [2];
    logic       d_done  [2];

    always #5 clk = ~clk;

    dual_nibble_loader #(.WIDTH(4), .HOLD_CYCLES(4)) u_h4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_data(in_data), .in_ready(d_ready[0]), .A(d_a[0]), .B(d_b[0]),
        .enab(d_enab[0]), .busy(d_busy[0]), .done(d_done[0])
    );

    dual_nibble_loader #(.WIDTH(4), .HOLD_CYCLES(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_data(in_data), .in_ready(d_ready[1]), .A(d_a[1]), .B(d_b[1]),
        .enab(d_enab[1]), .busy(d_busy[1]), .done(d_done[1])
    );

    // Model state: operands, whether A is already held, cycles of drive
    // remaining, and the done pulse.
    int         hold   [2] = '{4, 1};
    logic [3:0] m_a    [2];
    logic [3:0] m_b    [2];
    bit         m_hasa [2];
    int         m_left [2];
    bit         m_done [2];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[h%0d] got=%0h exp=%0h at %0t", tag, hold[idx], got, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 2; i++) begin
            m_a[i] = 0; m_b[i] = 0; m_hasa[i] = 0; m_left[i] = 0; m_done[i] = 0;
        end
    endtask

    // One clock edge of the model, using the inputs as they were before the edge.
    task automatic mdl_step();
        for (int i = 0; i < 2; i++) begin
            if (clear) begin
                m_a[i] = 0; m_b[i] = 0; m_hasa[i] = 0; m_left[i] = 0; m_done[i] = 0;
            end else begin
                m_done[i] = (m_left[i] == 1);
                if (m_left[i] > 0) m_left[i]--;
                else if (in_valid) begin
                    if (!m_hasa[i]) begin m_a[i] = in_data; m_hasa[i] = 1; end
                    else begin m_b[i] = in_data; m_hasa[i] = 0; m_left[i] = hold[i]; end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk("A",        i, 32'(d_a[i]),     32'(m_a[i]));
            chk("B",        i, 32'(d_b[i]),     32'(m_b[i]));
            chk("enab",     i, 32'(d_enab[i]),  32'(m_left[i] > 0));
            chk("in_ready", i, 32'(d_ready[i]), 32'(m_left[i] == 0));
            chk("busy",     i, 32'(d_busy[i]),  32'(m_hasa[i] || m_left[i] > 0));
            chk("done",     i, 32'(d_done[i]),  32'(m_done[i]));
        end
    endtask

    // Called at a negedge: apply inputs, take one edge, and check at the next negedge.
    // acc reports whether the HOLD_CYCLES=4 instance should have accepted the nibble.
    task automatic cyc(input bit v, input logic [3:0] d, input bit c, output bit acc);
        in_valid = v; in_data = d; clear = c;
        acc = v && !c && (m_left[0] == 0);
        @(posedge clk);
        mdl_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_cycles(input int n);
        bit acc;
        for (int k = 0; k < n; k++) cyc(0, 4'($urandom), 0, acc);
    endtask

    initial begin
        bit acc;
        logic [3:0] q[$];

        mdl_reset();
        #12;
        // Check the reset state while reset is held.
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all();

        // A=1110, B=0100, then the full window and the done pulse.
        cyc(1, 4'b1110, 0, acc);
        cyc(1, 4'b0100, 0, acc);
        chk("dir_A", 0, 32'(d_a[0]), 32'hE);
        chk("dir_B", 0, 32'(d_b[0]), 32'h4);
        idle_cycles(6);

        // Hold in_valid high with four nibbles. A nibble is dropped from the
        // queue only when the model says the transfer was accepted.
        q = '{4'b1110, 4'b0101, 4'b0011, 4'b1001};
        for (int k = 0; k < 12 && q.size() > 0; k++) begin
            cyc(1, q[0], 0, acc);
            if (acc) void'(q.pop_front());
        end
        chk("queue_drained", 0, 32'(q.size()), 0);
        idle_cycles(6);

        // Pulse clear during the 2nd DRIVE cycle.
        cyc(1, 4'h9, 0, acc);
        cyc(1, 4'h6, 0, acc);
        idle_cycles(1);
        cyc(0, 4'h0, 1, acc);
        chk("clr_enab", 0, 32'(d_enab[0]), 0);
        idle_cycles(3);

        // Assert clear on the same edge as the B transfer.
        cyc(1, 4'hA, 0, acc);
        cyc(1, 4'h7, 1, acc);
        chk("clrB_B", 0, 32'(d_b[0]), 0);
        idle_cycles(2);

        // Pull rst_n low between clock edges in the middle of DRIVE.
        cyc(1, 4'h3, 0, acc);
        cyc(1, 4'hC, 0, acc);
        idle_cycles(1);
        #2 rst_n = 1'b0;
        #1;
        mdl_reset();
        check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        idle_cycles(5);
        // After reset, the first transfer is taken as A.
        cyc(1, 4'h5, 0, acc);
        chk("post_rst_A", 0, 32'(d_a[0]), 32'h5);

        // Randomized traffic.
        for (int k = 0; k < 400; k++)
            cyc(($urandom_range(0, 9) < 7), 4'($urandom), ($urandom_range(0, 39) == 0), acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
